// File: rtl/wildcube_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wildcube_pkg : game-state encoding and default game timing constants
// Revision     : 1.0
// ---------------------------------------------------------------------------
package wildcube_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PLAY = 3'd2;
  localparam logic [2:0] ST_HIT  = 3'd3;
  localparam logic [2:0] ST_OVER = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_PLAY = ST_PLAY,
    S_HIT  = ST_HIT,
    S_OVER = ST_OVER
  } state_t;

  localparam int DEF_LIVES      = 3;
  localparam int DEF_HIT_FRAMES = 64;
  localparam int DEF_SCORE_DIV  = 64;
  localparam int DEF_FLASH_SLOW = 16;
  localparam int DEF_FLASH_FAST = 8;

  localparam int HIT_CNT_W   = 7;
  localparam int SCORE_CNT_W = 6;
  localparam int FLASH_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/frame_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_divider : counts enabled frame pulses, wraps after reaching 'last'
// Revision      : 1.0
// ---------------------------------------------------------------------------
module frame_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // 'last' is limit-1 so a limit equal to 2**WIDTH still fits the counter
  assign tc = en && !clr && (count == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == last) ? '0 : count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/collision_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// collision_monitor : cube/line overlap detection and frame-rate game FSM
// Revision          : 1.0
// ---------------------------------------------------------------------------
module collision_monitor
  import wildcube_pkg::*;
#(
  parameter int NLINES     = 5,
  parameter int LIVES      = DEF_LIVES,
  parameter int HIT_FRAMES = DEF_HIT_FRAMES,
  parameter int SCORE_DIV  = DEF_SCORE_DIV,
  parameter int FLASH_SLOW = DEF_FLASH_SLOW,
  parameter int FLASH_FAST = DEF_FLASH_FAST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame,
  input  logic              start_machine,
  input  logic              cube,
  input  logic [NLINES-1:0] h_line,
  output logic              stop,
  output logic              flash,
  output logic              load_counter,
  output logic              collide,
  output logic [1:0]        lives,
  output logic [7:0]        score
);

  localparam logic [HIT_CNT_W-1:0]   HIT_LAST   = HIT_CNT_W'(HIT_FRAMES - 1);
  localparam logic [SCORE_CNT_W-1:0] SCORE_LAST = SCORE_CNT_W'(SCORE_DIV - 1);
  localparam logic [FLASH_CNT_W-1:0] SLOW_LAST  = FLASH_CNT_W'(FLASH_SLOW - 1);
  localparam logic [FLASH_CNT_W-1:0] FAST_LAST  = FLASH_CNT_W'(FLASH_FAST - 1);
  localparam logic [1:0]             LIVES_INIT = 2'(LIVES);

  state_t state, next_state;
  logic   flag;
  logic   overlap, hit_now, clean_frame, start_play, state_chg;
  logic   flash_tc, hit_tc, score_tc;
  logic   stop_nxt, load_nxt, flash_nxt;

  // an overlap on the frame cycle itself belongs to the frame that is ending
  assign overlap     = cube & (|h_line);
  assign hit_now     = (state == S_PLAY) && frame && (flag || overlap);
  assign clean_frame = (state == S_PLAY) && frame && !(flag || overlap);
  assign start_play  = (state == S_LOAD) && frame;
  assign state_chg   = (next_state != state);

  frame_divider #(.WIDTH(FLASH_CNT_W)) u_flash_div (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg || (state == S_LOAD) || (state == S_PLAY)),
    .en    (frame),
    .last  ((state == S_HIT) ? FAST_LAST : SLOW_LAST),
    .tc    (flash_tc)
  );

  frame_divider #(.WIDTH(HIT_CNT_W)) u_hit_div (
    .clk   (clk),
    .reset (reset),
    .clr   (state != S_HIT),
    .en    (frame),
    .last  (HIT_LAST),
    .tc    (hit_tc)
  );

  frame_divider #(.WIDTH(SCORE_CNT_W)) u_score_div (
    .clk   (clk),
    .reset (reset),
    .clr   (start_play),
    .en    (clean_frame),
    .last  (SCORE_LAST),
    .tc    (score_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_OVER: if (start_machine) next_state = S_LOAD;
      S_LOAD:         if (frame) next_state = S_PLAY;
      S_PLAY:         if (hit_now) next_state = S_HIT;
      S_HIT:          if (hit_tc) next_state = (lives == 2'd0) ? S_OVER : S_PLAY;
      default:        next_state = S_IDLE;
    endcase

    stop_nxt = (next_state == S_PLAY);
    load_nxt = (next_state == S_IDLE) || (next_state == S_LOAD) || (next_state == S_OVER);

    // the blink phase restarts dark whenever a blinking state is entered
    flash_nxt = flash;
    if (state_chg && ((next_state == S_IDLE) || (next_state == S_HIT) || (next_state == S_OVER)))
      flash_nxt = 1'b0;
    else if ((next_state == S_LOAD) || (next_state == S_PLAY))
      flash_nxt = 1'b1;
    else if (flash_tc)
      flash_nxt = ~flash;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop         <= 1'b0;
      load_counter <= 1'b1;
      flash        <= 1'b0;
      collide      <= 1'b0;
      flag         <= 1'b0;
      lives        <= LIVES_INIT;
      score        <= 8'd0;
    end else begin
      stop         <= stop_nxt;
      load_counter <= load_nxt;
      flash        <= flash_nxt;
      collide      <= hit_now;

      if (frame)                            flag <= 1'b0;
      else if ((state == S_PLAY) && overlap) flag <= 1'b1;

      if (start_play)   lives <= LIVES_INIT;
      else if (hit_now) lives <= lives - 2'd1;

      if (start_play)                          score <= 8'd0;
      else if (score_tc && (score != 8'hFF))   score <= score + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/collision_monitor.md
# collision_monitor

Game-control stage directly downstream of the five horizontal-line generators. Each pixel clock it compares the player cube pixel against the line pixels and latches any overlap for the current frame. At each frame boundary it runs the game state machine, which drives the shared `stop`, `flash` and `load_counter` controls back into every line generator. It also maintains lives and a survival score for the HUD.

## Interface
Parameters:
- `NLINES`, 5: number of line-pixel inputs.
- `LIVES`, 3: lives loaded at game start.
- `HIT_FRAMES`, 64: frames spent in HIT before resuming.
- `SCORE_DIV`, 64: PLAY frames per score increment.
- `FLASH_SLOW`, 16: frames per flash toggle in IDLE/OVER.
- `FLASH_FAST`, 8: frames per flash toggle in HIT.

Ports:
- `clk` in 1: pixel clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `frame` in 1: one-`clk` pulse per frame, asserted after the last visible pixel.
- `start_machine` in 1: one-`clk` start request, already debounced.
- `cube` in 1: cube pixel for the current scan position.
- `h_line` in `NLINES`: line pixels, one per generator, same scan position as `cube`.
- `stop` out 1: 1 = lines move and display solid; 0 = lines frozen and shown only when `flash`=1.
- `flash` out 1: blink phase.
- `load_counter` out 1: holds line position counters at their start values.
- `collide` out 1: one-`clk` pulse on entry to HIT.
- `lives` out 2: remaining lives.
- `score` out 8: survival score.

## Operation
States: IDLE, LOAD, PLAY, HIT, OVER. Encoding is in the package.

- **IDLE** (state after reset)
  - `stop`=0, `load_counter`=1, flash divider = `FLASH_SLOW`.
  - `start_machine` → LOAD on the next `clk`.
- **LOAD**
  - `stop`=0, `load_counter`=1, `flash`=1.
  - On the first `frame` → PLAY. This guarantees the line counters see at least one frame edge with load asserted.
  - On that transition: `lives`←`LIVES`, `score`←0, all frame counters cleared.
- **PLAY**
  - `stop`=1, `load_counter`=0, `flash`=1.
  - Overlap flag sets on any `clk` where `cube & |h_line`.
  - At `frame` with flag set → HIT: `lives`−1, `collide` pulses.
  - At `frame` with flag clear → score-divider counter +1. On reaching `SCORE_DIV`, the counter wraps to 0 and `score`+1, saturating at 255.
- **HIT**
  - `stop`=0, `load_counter`=0 (lines freeze in place), flash divider = `FLASH_FAST`.
  - After `HIT_FRAMES` frame pulses: → OVER if `lives`=0, else → PLAY. Lines resume from their frozen position.
  - Overlap is ignored in HIT.
- **OVER**
  - `stop`=0, `load_counter`=1, flash divider = `FLASH_SLOW`.
  - `score` and `lives` (0) are held.
  - `start_machine` → LOAD.
- `start_machine` is ignored in LOAD, PLAY and HIT.

## Timing
- Reset values: state=IDLE, `stop`=0, `flash`=0, `load_counter`=1, `collide`=0, `lives`=`LIVES`, `score`=0, overlap flag=0, all counters=0.
- All outputs are registered. Overlap on cycle n is visible in the flag at n+1.
- A state change taken at `frame` on cycle n shows on outputs at n+1.
- The overlap flag clears on every `frame` pulse. Overlap in the same cycle as `frame` belongs to the ending frame and is included in that decision.
- The flash divider resets to 0 and `flash` resets to 0 on entry to IDLE, HIT or OVER. `flash` toggles when the divider reaches its limit at a `frame` pulse.
- If `start_machine` and `frame` coincide in IDLE/OVER, the next state is LOAD, which then waits for the next `frame`.
- Counter widths: frame counter 7 bits (HIT), score divider 6 bits, flash divider 4 bits.
- Asserting `reset` mid-game returns all registers to their reset values immediately.

## Structure
- Package `wildcube_pkg`:
  - state encoding localparams.
  - default values for `LIVES`, `HIT_FRAMES`, `SCORE_DIV`, `FLASH_SLOW`, `FLASH_FAST`.
- Sub-module `frame_divider`:
  - frame-pulse counter with a selectable limit, clear input and terminal-count output.
  - instantiated once for flash, once for HIT duration, once for score.

## Test plan
- **Reset, idle:** reset, then 40 frames idle → `stop`=0, `load_counter`=1, `flash` toggles on frames 16 and 32, `lives`=3, `score`=0.
- **Start:** `start_machine` pulse, then one `frame` → PLAY with `stop`=1, `load_counter`=0. Run 128 clean frames → `score`=2.
- **Single hit:** assert `cube` and `h_line[2]` together for 1 `clk` mid-frame → at `frame`, `collide` pulses once, `lives`=2, `stop`=0. `flash` toggles every 8 frames. PLAY resumes after exactly 64 frames.
- **Boundary overlap:** overlap in the same cycle as `frame` → HIT is entered at that `frame`. Overlap on the cycle after `frame` → HIT is entered at the following `frame`.
- **Game over:** 3 hits → OVER with `lives`=0 and `score` frozen. `start_machine` → LOAD, then at next `frame` `lives`=3, `score`=0.
- **Saturation and reset:** preload `score`=255 via force, run 64 clean frames → `score` stays 255. Assert `reset` mid-HIT → IDLE and all reset values next cycle.
